fault_restart_ctrl: RTL and testbench

FAULT_RESTART_CTRL -- requirements
Module: fault_restart_ctrl

---
 rtl/fault_restart_pkg.sv | 33 +++
 rtl/fault_restart_ctrl_sync_rise.sv | 29 ++
 rtl/fault_restart_ctrl.sv | 155 +++++++++++++++
 tb/tb_fault_restart_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_restart_pkg.sv
// Shared definitions for the fault restart controller: one-hot state encoding,
// default timing constants and the timer sizing helper.
package fault_restart_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        COOL  = 5'b00010,
        PULSE = 5'b00100,
        ACK   = 5'b01000,
        LOCK  = 5'b10000
    } state_t;

    localparam int DEF_COOL_CYC  = 5000000;
    localparam int DEF_PULSE_CYC = 16;
    localparam int DEF_ACK_CYC   = 8;
    localparam int DEF_RETRY_MAX = 3;
    localparam int DEF_CLEAR_CYC = 50000000;

    // One shared timer counts every phase, so it must hold the largest terminal count.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/fault_restart_ctrl_sync_rise.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// rising-edge detector on the synchronized level.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic sync_d_r;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
        end else begin
            meta_r   <= din;
            sync_r   <= meta_r;
            sync_d_r <= sync_r;
        end
    end

    assign rise = sync_r & ~sync_d_r;

endmodule

// File: rtl/fault_restart_ctrl.sv
// Automatic restart controller for a tripped protection block.
// Build option: define AUTO_RESTART_EN for cooldown/retry restarts; otherwise manual-only.
module fault_restart_ctrl
    import fault_restart_pkg::*;
#(
    parameter int COOL_CYC  = DEF_COOL_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int ACK_CYC   = DEF_ACK_CYC,
    parameter int RETRY_MAX = DEF_RETRY_MAX,
    parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
    input  logic       CLK_50M,
    input  logic       Rst_n,
    input  logic       PWMEN,
    input  logic       ManReq,
    output logic       ResetD,
    output logic       Lockout,
    output logic [1:0] RetryCnt
);

    localparam int TW = timer_width(COOL_CYC, CLEAR_CYC, PULSE_CYC, ACK_CYC);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_CYC - 1);

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          pwmen_d_r;
    logic          man_ev_s;
    logic          fault_ev_s;

    sync_rise u_man_sync (
        .clk   (CLK_50M),
        .rst_n (Rst_n),
        .din   (ManReq),
        .rise  (man_ev_s)
    );

    assign fault_ev_s = pwmen_d_r & ~PWMEN;

`ifdef AUTO_RESTART_EN
    localparam logic [TW-1:0] COOL_LAST  = TW'(COOL_CYC - 1);
    localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYC - 1);
    localparam logic [1:0]    RETRY_LIM  = (RETRY_MAX > 3) ? 2'd3 : 2'(RETRY_MAX);

    logic       heal_done_s;
    logic [1:0] retry_base_s;

    // In IDLE the timer is the healthy counter; an expiring window forgives past retries first.
    assign heal_done_s  = (timer_r == CLEAR_LAST);
    assign retry_base_s = heal_done_s ? 2'd0 : RetryCnt;
`endif

    // Restart sequencer with registered outputs.
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            pwmen_d_r <= 1'b1;
            ResetD    <= 1'b0;
            Lockout   <= 1'b0;
            RetryCnt  <= 2'd0;
        end else begin
            pwmen_d_r <= PWMEN;
            case (state_r)
                IDLE: begin
`ifdef AUTO_RESTART_EN
                    if (fault_ev_s) begin
                        timer_r <= '0;
                        if (retry_base_s < RETRY_LIM) begin
                            state_r  <= COOL;
                            RetryCnt <= retry_base_s + 2'd1;
                        end else begin
                            state_r  <= LOCK;
                            Lockout  <= 1'b1;
                            RetryCnt <= retry_base_s;
                        end
                    end else if (PWMEN) begin
                        if (heal_done_s) begin
                            RetryCnt <= 2'd0;
                            timer_r  <= '0;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end else begin
                        timer_r <= '0;
                    end
`else
                    timer_r <= '0;
                    if (fault_ev_s) begin
                        state_r <= LOCK;
                        Lockout <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
`endif
                end
`ifdef AUTO_RESTART_EN
                COOL: begin
                    if (man_ev_s || (timer_r == COOL_LAST)) begin
                        state_r <= PULSE;
                        timer_r <= '0;
                        ResetD  <= 1'b1;
                        if (man_ev_s) begin
                            RetryCnt <= 2'd0;
                        end else begin
                            RetryCnt <= RetryCnt;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
`endif
                PULSE: begin
                    if (timer_r == PULSE_LAST) begin
                        state_r <= ACK;
                        timer_r <= '0;
                        ResetD  <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ACK: begin
                    if (PWMEN) begin
                        state_r <= IDLE;
                        timer_r <= '0;
                    end else if (timer_r == ACK_LAST) begin
                        state_r <= LOCK;
                        timer_r <= '0;
                        Lockout <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                LOCK: begin
                    timer_r <= '0;
                    if (man_ev_s) begin
                        state_r  <= PULSE;
                        ResetD   <= 1'b1;
                        Lockout  <= 1'b0;
                        RetryCnt <= 2'd0;
                    end else begin
                        state_r <= LOCK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= '0;
                    ResetD  <= 1'b0;
                    Lockout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_restart_ctrl.sv
// Randomized scoreboard bench for fault_restart_ctrl against a timeline reference model.
module tb_fault_restart_ctrl;

    localparam int COOL  = 100;
    localparam int PULSE = 16;
    localparam int ACK   = 8;
    localparam int RMAX  = 3;
    localparam int CLEAR = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwmen;
    logic       man_req;
    logic       reset_d;
    logic       lockout;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    fault_restart_ctrl #(
        .COOL_CYC  (COOL),
        .PULSE_CYC (PULSE),
        .ACK_CYC   (ACK),
        .RETRY_MAX (RMAX),
        .CLEAR_CYC (CLEAR)
    ) dut (
        .CLK_50M  (clk),
        .Rst_n    (rst_n),
        .PWMEN    (pwmen),
        .ManReq   (man_req),
        .ResetD   (reset_d),
        .Lockout  (lockout),
        .RetryCnt (retry_cnt)
    );

    typedef struct packed {
        logic       rd;
        logic       lk;
        logic [1:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: absolute edge numbers for cooldown start and pulse start.
    int n          = 0;
    bit m_locked   = 1'b0;
    int m_retries  = 0;
    int m_pb       = -1;
    int m_cool     = -1;
    int m_healthy  = 0;
    bit m_prev_pw  = 1'b1;
    bit mr_hist[$];

    task automatic model_edge(input bit rn, input bit pw, input bit mr);
        bit   man;
        bit   fault;
        bit   expire;
        int   base;
        exp_t e;
        man = mr_hist[1] & ~mr_hist[2];
        if (!rn) begin
            m_locked  = 1'b0;
            m_retries = 0;
            m_pb      = -1;
            m_cool    = -1;
            m_healthy = 0;
            m_prev_pw = 1'b1;
            mr_hist   = '{1'b0, 1'b0, 1'b0};
        end else begin
            fault = m_prev_pw & ~pw;
            if (m_locked) begin
                if (man) begin
                    m_locked  = 1'b0;
                    m_retries = 0;
                    m_pb      = n;
                end
            end else if (m_cool >= 0) begin
                if (man) begin
                    m_pb      = n;
                    m_retries = 0;
                    m_cool    = -1;
                end else if (n == m_cool + COOL) begin
                    m_pb   = n;
                    m_cool = -1;
                end
            end else if (m_pb >= 0 && n <= m_pb + PULSE) begin
                m_pb = m_pb;
            end else if (m_pb >= 0) begin
                if (pw) begin
                    m_pb      = -1;
                    m_healthy = 0;
                end else if (n == m_pb + PULSE + ACK) begin
                    m_locked = 1'b1;
                    m_pb     = -1;
                end
            end else begin
`ifdef AUTO_RESTART_EN
                expire = (m_healthy == CLEAR - 1);
                if (fault) begin
                    base      = expire ? 0 : m_retries;
                    m_healthy = 0;
                    if (base < RMAX) begin
                        m_retries = base + 1;
                        m_cool    = n;
                    end else begin
                        m_retries = base;
                        m_locked  = 1'b1;
                    end
                end else if (pw) begin
                    if (expire) begin
                        m_retries = 0;
                        m_healthy = 0;
                    end else begin
                        m_healthy++;
                    end
                end else begin
                    m_healthy = 0;
                end
`else
                expire = 1'b0;
                base   = 0;
                if (fault) m_locked = 1'b1;
`endif
            end
            m_prev_pw = pw;
            mr_hist.push_front(mr);
            void'(mr_hist.pop_back());
        end
        e.rd = (m_pb >= 0) && (n >= m_pb) && (n <= m_pb + PULSE - 1);
        e.lk = m_locked;
        e.rc = m_retries[1:0];
        exp_q.push_back(e);
        n++;
    endtask

    task automatic cyc(input bit r, input bit p, input bit m);
        @(negedge clk);
        rst_n   = r;
        pwmen   = p;
        man_req = m;
        model_edge(r, p, m);
        @(posedge clk);
    endtask

    task automatic hold(input int cycles, input bit p, input bit m);
        for (int i = 0; i < cycles; i++) cyc(1'b1, p, m);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: one expectation per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (reset_d !== e.rd) begin
                    bad++;
                    $display("FAIL ResetD edge=%0d got=%0b expected=%0b", n, reset_d, e.rd);
                end
                total++;
                if (lockout !== e.lk) begin
                    bad++;
                    $display("FAIL Lockout edge=%0d got=%0b expected=%0b", n, lockout, e.lk);
                end
                total++;
                if (retry_cnt !== e.rc) begin
                    bad++;
                    $display("FAIL RetryCnt edge=%0d got=%0d expected=%0d", n, retry_cnt, e.rc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int len;
        int guard;
        rst_n   = 1'b0;
        pwmen   = 1'b1;
        man_req = 1'b0;
        mr_hist = '{1'b0, 1'b0, 1'b0};

        do_reset();
        hold(20, 1'b1, 1'b0);
        // single trip, PWMEN back two cycles after the pulse ends
        hold(COOL + PULSE + 2, 1'b0, 1'b0);
        hold(300, 1'b1, 1'b0);
        // four spaced trips exhaust the retries
        do_reset();
        hold(10, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            hold(2, 1'b0, 1'b0);
            hold(198, 1'b1, 1'b0);
        end
        hold(5, 1'b1, 1'b1);
        hold(40, 1'b1, 1'b0);
        // no acknowledge: lock, release manually, then reset mid-pulse
        hold(140, 1'b0, 1'b0);
        hold(3, 1'b0, 1'b1);
        hold(6, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        hold(5, 1'b1, 1'b0);
`ifdef AUTO_RESTART_EN
        do_reset();
        hold(10, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0);
        hold(1200, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0);
        guard = 0;
        while ((m_healthy != CLEAR - 1) && (guard < 2000)) begin
            cyc(1'b1, 1'b1, 1'b0);
            guard++;
        end
        hold(2, 1'b0, 1'b0);
        hold(300, 1'b1, 1'b0);
`endif

        for (int ep = 0; ep < 50; ep++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                len = $urandom_range(1, 160);
                hold(len, 1'b0, 1'b0);
                hold($urandom_range(1, 60), 1'b1, 1'b0);
            end else if (kind <= 5) begin
                hold($urandom_range(20, 1050), 1'b1, 1'b0);
            end else if (kind <= 7) begin
                len = $urandom_range(1, 6);
                hold(len, 1'($urandom_range(0, 1)), 1'b1);
                hold($urandom_range(5, 40), 1'b1, 1'b0);
            end else if (kind == 8) begin
                for (int i = 0; i < 30; i++) begin
                    cyc(1'b1, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
                end
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end else begin
                    hold(50, 1'b1, 1'b0);
                end
            end
        end

        hold(5, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
